// File: rtl/cpu.sv
// cpu: 8-bit accumulator CPU with an internal 256-byte RAM.
// A T-state timer (T0..T3) and an opcode decoder sequence fetch, operand
// fetch and execute over one shared address/data bus.
// Ports:
//   clk   - system clock; all state changes on the rising edge
//   reset - synchronous, active-high; clears CPU registers, keeps RAM contents
// Internal nets address_bus, data_bus, OE_M, WE_M, en_timer_decoder and HLT,
// and instance RAM with array mem, are kept at fixed names on purpose.

module cpu_ram #(
    parameter int DATA_WIDTH   = 8,
    parameter int MEMORY_DEPTH = 256,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  oe_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int IW = $clog2(MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] mem [0:MEMORY_DEPTH-1];
    logic                  sel_s;
    logic                  unused_s;

    // Only the low index bits select a word; the middle address bits alias.
    assign sel_s    = ~addr_i[ADDR_WIDTH-1];
    assign unused_s = ^addr_i[ADDR_WIDTH-2:IW];

    // Combinational read; returns zero when deselected or not enabled.
    always_comb begin
        rdata_o = {DATA_WIDTH{1'b0}};
        if (oe_i && sel_s) begin
            rdata_o = mem[addr_i[IW-1:0]];
        end else begin
            rdata_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Synchronous write; no reset so contents survive a CPU reset.
    always_ff @(posedge clk_i) begin
        if (we_i && sel_s) begin
            mem[addr_i[IW-1:0]] <= wdata_i;
        end
    end
endmodule

module cpu #(
    parameter int DATA_WIDTH   = 8,
    parameter int MEMORY_DEPTH = 256,
    parameter int ADDR_WIDTH   = 16
) (
    input logic clk,
    input logic reset
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstate_e;

    tstate_e         t_q, t_d;
    logic [7:0]      a_q, a_d, b_q, b_d, ir_q, ir_d;
    logic [15:0]     pc_q, pc_d, mar_q, mar_d;
    logic            z_q, z_d, c_q, c_d, hlt_q, hlt_d;

    logic [ADDR_WIDTH-1:0] address_bus;
    logic [DATA_WIDTH-1:0] data_bus;
    logic                  OE_M, WE_M, en_timer_decoder, HLT;

    logic [15:0] addr_s;
    logic        oe_s, we_s, drive_a_s;
    logic [7:0]  ram_rdata_s;
    logic [8:0]  alu_s;
    logic        op_imm_s, op_mem_s, op_jmp_s;

    assign op_imm_s = (ir_q == 8'h01) || (ir_q == 8'h02);
    assign op_mem_s = (ir_q == 8'h03) || (ir_q == 8'h04);
    assign op_jmp_s = (ir_q == 8'h20) || (ir_q == 8'h21) || (ir_q == 8'h22);

    assign HLT              = hlt_q;
    assign en_timer_decoder = ~hlt_q;

    // Bus control: who addresses RAM and in which direction, per T-state.
    always_comb begin
        addr_s    = pc_q;
        oe_s      = 1'b0;
        we_s      = 1'b0;
        drive_a_s = 1'b0;
        case (t_q)
            T0: oe_s = 1'b1;
            T1: begin
                if (op_imm_s || op_mem_s || op_jmp_s) oe_s = 1'b1;
                else                                  oe_s = 1'b0;
            end
            T2: begin
                if (op_mem_s || op_jmp_s) oe_s = 1'b1;
                else                      oe_s = 1'b0;
            end
            T3: begin
                if (ir_q == 8'h03) begin
                    addr_s = mar_q;
                    oe_s   = 1'b1;
                end else if (ir_q == 8'h04) begin
                    addr_s    = mar_q;
                    we_s      = 1'b1;
                    drive_a_s = 1'b1;
                end else begin
                    addr_s = pc_q;
                end
            end
            default: addr_s = pc_q;
        endcase
    end

    // Freezing the timer also disables every bus strobe; reset kills a pending write.
    assign address_bus = addr_s;
    assign OE_M        = oe_s & en_timer_decoder;
    assign WE_M        = we_s & en_timer_decoder & ~reset;
    assign data_bus    = (drive_a_s & en_timer_decoder) ? a_q : ram_rdata_s;

    cpu_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) RAM (
        .clk_i  (clk),
        .addr_i (address_bus),
        .wdata_i(data_bus),
        .we_i   (WE_M),
        .oe_i   (OE_M),
        .rdata_o(ram_rdata_s)
    );

    // ALU; bit 8 is carry for add/inc and borrow for sub/dec, zero for logic ops.
    always_comb begin
        case (ir_q)
            8'h10:   alu_s = {1'b0, a_q} + {1'b0, b_q};
            8'h11:   alu_s = {1'b0, a_q} - {1'b0, b_q};
            8'h12:   alu_s = {1'b0, a_q & b_q};
            8'h13:   alu_s = {1'b0, a_q | b_q};
            8'h14:   alu_s = {1'b0, a_q ^ b_q};
            8'h15:   alu_s = {1'b0, ~a_q};
            8'h16:   alu_s = {1'b0, a_q} + 9'd1;
            8'h17:   alu_s = {1'b0, a_q} - 9'd1;
            default: alu_s = {1'b0, a_q};
        endcase
    end

    // Next-state decode for the timer and all registers.
    always_comb begin
        t_d   = T0;
        a_d   = a_q;
        b_d   = b_q;
        ir_d  = ir_q;
        pc_d  = pc_q;
        mar_d = mar_q;
        z_d   = z_q;
        c_d   = c_q;
        hlt_d = hlt_q;
        case (t_q)
            T0: begin
                ir_d = data_bus;
                pc_d = pc_q + 16'd1;
                t_d  = T1;
            end
            T1: begin
                case (ir_q)
                    8'h01: begin a_d = data_bus; pc_d = pc_q + 16'd1; end
                    8'h02: begin b_d = data_bus; pc_d = pc_q + 16'd1; end
                    8'h03, 8'h04, 8'h20, 8'h21, 8'h22: begin
                        mar_d = {mar_q[15:8], data_bus};
                        pc_d  = pc_q + 16'd1;
                        t_d   = T2;
                    end
                    8'h05: b_d = a_q;
                    8'h06: a_d = b_q;
                    8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17: begin
                        a_d = alu_s[7:0];
                        z_d = (alu_s[7:0] == 8'h00);
                        c_d = alu_s[8];
                    end
                    8'hFF:   hlt_d = 1'b1;
                    default: hlt_d = hlt_q;
                endcase
            end
            T2: begin
                case (ir_q)
                    8'h03, 8'h04: begin
                        mar_d = {data_bus, mar_q[7:0]};
                        pc_d  = pc_q + 16'd1;
                        t_d   = T3;
                    end
                    8'h20: pc_d = {data_bus, mar_q[7:0]};
                    8'h21: pc_d = z_q ? {data_bus, mar_q[7:0]} : pc_q + 16'd1;
                    8'h22: pc_d = c_q ? {data_bus, mar_q[7:0]} : pc_q + 16'd1;
                    default: pc_d = pc_q;
                endcase
            end
            T3: begin
                if (ir_q == 8'h03) a_d = data_bus;
                else               a_d = a_q;
            end
            default: t_d = T0;
        endcase
    end

    // State register; a deasserted en_timer_decoder freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_q   <= T0;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            ir_q  <= 8'h00;
            pc_q  <= 16'h0000;
            mar_q <= 16'h0000;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            hlt_q <= 1'b0;
        end else if (en_timer_decoder) begin
            t_q   <= t_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ir_q  <= ir_d;
            pc_q  <= pc_d;
            mar_q <= mar_d;
            z_q   <= z_d;
            c_q   <= c_d;
            hlt_q <= hlt_d;
        end else begin
            t_q   <= t_q;
            a_q   <= a_q;
            b_q   <= b_q;
            ir_q  <= ir_q;
            pc_q  <= pc_q;
            mar_q <= mar_q;
            z_q   <= z_q;
            c_q   <= c_q;
            hlt_q <= hlt_q;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs for the accumulator CPU, scoreboard-checked.
module tb_cpu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    cpu dut (
        .clk  (clk),
        .reset(reset)
    );

    always #5 clk = ~clk;

    localparam int K_A = 0, K_PC = 1, K_HLT = 2, K_C = 3, K_Z = 4, K_MEM = 5, K_BUS = 6;

    typedef struct {
        string name;
        int    kind;
        int    addr;
        int    exp;
    } chk_t;

    chk_t        sb_q[$];
    chk_t        mon_c;
    int          mon_act;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] tb_addr;
    logic [7:0]  tb_data;
    logic [7:0]  prog[$];

    function automatic int actual(input int kind, input int addr);
        case (kind)
            K_A:     return int'(dut.a_q);
            K_PC:    return int'(dut.pc_q);
            K_HLT:   return int'(dut.HLT);
            K_C:     return int'(dut.c_q);
            K_Z:     return int'(dut.z_q);
            K_MEM:   return int'(dut.RAM.mem[addr[7:0]]);
            K_BUS:   return int'(dut.data_bus);
            default: return -1;
        endcase
    endfunction

    // Monitor: compares every queued expectation against the DUT on the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_c   = sb_q.pop_front();
            mon_act = actual(mon_c.kind, mon_c.addr);
            checks++;
            if (mon_act != mon_c.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_c.name, mon_act, mon_c.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int k, input int a, input int e);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.addr = a;
        c.exp  = e;
        sb_q.push_back(c);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_force();
        force dut.en_timer_decoder = 1'b0;
    endtask

    task automatic end_force();
        release dut.en_timer_decoder;
        release dut.address_bus;
        release dut.data_bus;
        release dut.OE_M;
        release dut.WE_M;
    endtask

    task automatic ram_write(input logic [15:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        force dut.address_bus = tb_addr;
        force dut.data_bus    = tb_data;
        force dut.OE_M        = 1'b0;
        force dut.WE_M        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic ram_read_check(input string n, input logic [15:0] a, input int e);
        tb_addr = a;
        release dut.data_bus;
        force dut.address_bus = tb_addr;
        force dut.WE_M        = 1'b0;
        force dut.OE_M        = 1'b1;
        expect_v(n, K_BUS, 0, e);
        sync();
    endtask

    task automatic start_prog(input logic [7:0] fe_init);
        reset = 1'b1;
        begin_force();
        for (int i = 0; i < prog.size(); i++) ram_write(16'(i), prog[i]);
        ram_write(16'h00FE, fe_init);
        end_force();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string n);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            if (dut.HLT) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_halt: got HLT=0 after 300 cycles, expected 1", n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_v("rst_pc", K_PC, 0, 0);
        expect_v("rst_a", K_A, 0, 0);
        expect_v("rst_hlt", K_HLT, 0, 0);
        expect_v("rst_c", K_C, 0, 0);
        expect_v("rst_z", K_Z, 0, 0);
        sync();

        // LDI / STA / HLT
        prog = {8'h01, 8'h25, 8'h04, 8'hFE, 8'h00, 8'hFF};
        start_prog(8'h00);
        run_to_halt("p1");
        expect_v("p1_mem", K_MEM, 8'hFE, 8'h25);
        expect_v("p1_hlt", K_HLT, 0, 1);
        expect_v("p1_pc", K_PC, 0, 16'h0006);
        expect_v("p1_a", K_A, 0, 8'h25);
        sync();

        // ADD with carry out
        prog = {8'h01, 8'hF0, 8'h02, 8'h20, 8'h10, 8'h04, 8'hFE, 8'h00, 8'hFF};
        start_prog(8'h00);
        run_to_halt("p2");
        expect_v("p2_mem", K_MEM, 8'hFE, 8'h10);
        expect_v("p2_c", K_C, 0, 1);
        expect_v("p2_z", K_Z, 0, 0);
        expect_v("p2_pc", K_PC, 0, 16'h0009);
        sync();

        // SUB to zero then taken JZ
        prog = {8'h01, 8'h05, 8'h02, 8'h05, 8'h11, 8'h21, 8'h09, 8'h00, 8'hFF,
                8'h01, 8'hAA, 8'h04, 8'hFE, 8'h00, 8'hFF};
        start_prog(8'h5A);
        run_to_halt("p3");
        expect_v("p3_mem", K_MEM, 8'hFE, 8'hAA);
        expect_v("p3_pc", K_PC, 0, 16'h000F);
        expect_v("p3_z", K_Z, 0, 1);
        expect_v("p3_c", K_C, 0, 0);
        sync();

        // Same program, B=4: JZ falls through to HLT at 0x08
        prog[3] = 8'h04;
        start_prog(8'h5A);
        run_to_halt("p3b");
        expect_v("p3b_hlt", K_HLT, 0, 1);
        expect_v("p3b_pc", K_PC, 0, 16'h0009);
        expect_v("p3b_mem", K_MEM, 8'hFE, 8'h5A);
        expect_v("p3b_a", K_A, 0, 8'h01);
        expect_v("p3b_z", K_Z, 0, 0);
        sync();

        // DEC borrow, taken JC, INC wrap, LDA keeps flags
        prog = {8'h01, 8'h00, 8'h17, 8'h22, 8'h08, 8'h00, 8'hFF, 8'hFF,
                8'h16, 8'h03, 8'hFE, 8'h00, 8'hFF};
        start_prog(8'h5A);
        run_to_halt("p4");
        expect_v("p4_a", K_A, 0, 8'h5A);
        expect_v("p4_c", K_C, 0, 1);
        expect_v("p4_z", K_Z, 0, 1);
        expect_v("p4_pc", K_PC, 0, 16'h000D);
        sync();

        // Direct RAM access with the timer frozen
        reset = 1'b1;
        begin_force();
        for (int i = 0; i < 256; i++) ram_write(16'(i), 8'(255 - i));
        for (int i = 0; i < 256; i++) ram_read_check($sformatf("ram_%0d", i), 16'(i), 255 - i);
        ram_read_check("ram_8000", 16'h8000, 0);
        ram_write(16'h8002, 8'h11);
        ram_read_check("ram_alias_2", 16'h0002, 8'hFD);
        end_force();
        sync();

        // HLT freezes the CPU until reset
        prog = {8'h01, 8'h77, 8'hFF};
        start_prog(8'h00);
        run_to_halt("p5");
        repeat (50) @(posedge clk);
        #1;
        expect_v("p5_a", K_A, 0, 8'h77);
        expect_v("p5_pc", K_PC, 0, 16'h0003);
        expect_v("p5_hlt", K_HLT, 0, 1);
        sync();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_v("p5_rst_pc", K_PC, 0, 0);
        expect_v("p5_rst_hlt", K_HLT, 0, 0);
        expect_v("p5_rst_a", K_A, 0, 0);
        sync();

        // Reset during STA T3 aborts the write
        prog = {8'h01, 8'h33, 8'h04, 8'hFE, 8'h00, 8'hFF};
        start_prog(8'h5A);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(posedge clk);
                #1;
                if (2'(dut.t_q) == 2'd3 && dut.ir_q == 8'h04) hit = 1'b1;
            end
            if (!hit) begin
                checks++;
                errors++;
                $display("FAIL p6_t3: got no STA T3 within 50 cycles, expected one");
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_v("p6_mem", K_MEM, 8'hFE, 8'h5A);
        expect_v("p6_pc", K_PC, 0, 0);
        expect_v("p6_a", K_A, 0, 0);
        sync();
        reset = 1'b0;
        sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
